// File: rtl/fp_pkg.sv
// Shared FP32 types and constants for the accumulation datapath.
package fp_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP32_ZERO = 32'h0000_0000;
  localparam fp32_t FP32_ONE  = 32'h3F80_0000;
  localparam fp32_t FP32_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } fp_accum_state_e;

endpackage

// File: rtl/fp_adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
// Subnormal operands are handled; any NaN result is the canonical quiet NaN.
module fp_adder
  import fp_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  output fp32_t sum
);

  fp32_t       big, sml;
  logic [7:0]  e_big, e_sml, d;
  logic [26:0] m_big, m_sml, m_sh, norm;
  logic [27:0] mag;
  logic [4:0]  lz;
  logic [9:0]  e_n, e_r;
  logic [24:0] mant_r;
  logic        a_nan, b_nan, a_inf, b_inf, rnd_up;

  assign a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  assign a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);

  always_comb begin
    if (a[30:0] >= b[30:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    e_big = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    e_sml = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    m_big = {big[30:23] != 8'd0, big[22:0], 3'b000};
    m_sml = {sml[30:23] != 8'd0, sml[22:0], 3'b000};
    d     = e_big - e_sml;

    // Three guard bits plus a sticky LSB keep RNE exact through alignment.
    if (d >= 8'd27) m_sh = {26'd0, |m_sml};
    else m_sh = (m_sml >> d) | {26'd0, |(m_sml & ((27'd1 << d) - 27'd1))};

    if (big[31] == sml[31]) mag = {1'b0, m_big} + {1'b0, m_sh};
    else mag = {1'b0, m_big} - {1'b0, m_sh};

    lz = 5'd0;
    for (int i = 0; i < 27; i++)
      if (mag[i]) lz = 5'(26 - i);

    if (mag[27]) begin
      norm = {mag[27:2], mag[1] | mag[0]};
      e_n  = {2'b00, e_big} + 10'd1;
    end else if ({3'b000, lz} < e_big) begin
      norm = mag[26:0] << lz;
      e_n  = {2'b00, e_big} - {5'd0, lz};
    end else begin
      norm = mag[26:0] << (e_big - 8'd1);
      e_n  = 10'd0;
    end

    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r = {1'b0, norm[26:3]} + {24'd0, rnd_up};
    e_r    = e_n;
    if (mant_r[24]) e_r = e_n + 10'd1;
    else if ((e_n == 10'd0) && mant_r[23]) e_r = 10'd1;

    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) sum = FP32_QNAN;
    else if (a_inf) sum = a;
    else if (b_inf) sum = b;
    else if (mag == 28'd0) sum = {big[31] & sml[31], 31'd0};
    else if (e_r >= 10'd255) sum = {big[31], 8'hFF, 23'd0};
    else sum = {big[31], e_r[7:0], mant_r[24] ? 23'd0 : mant_r[22:0]};
  end

endmodule

// File: rtl/fp_accum_ctrl.sv
// Reduces a job of len FP32 elements to one sum through a single shared fp_adder.
// Build option FP_ACCUM_BIAS_EN seeds the accumulator from a bias port sampled with start.
//   IDLE  | waiting for start
//   ACCUM | accepting elements until cnt reaches len
//   DONE  | presenting the sum until out_ready
module fp_accum_ctrl
  import fp_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
`ifdef FP_ACCUM_BIAS_EN
  input  fp32_t            bias,
`endif
  output logic             busy,
  input  logic             in_valid,
  input  fp32_t            in_data,
  output logic             in_ready,
  output logic             out_valid,
  output fp32_t            out_data,
  input  logic             out_ready
);

  fp_accum_state_e  state_q, state_d;
  fp32_t            acc_q, acc_d, add_sum, seed;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic             load_direct;

  fp_adder u_fp_adder (
    .a   (acc_q),
    .b   (in_data),
    .sum (add_sum)
  );

`ifdef FP_ACCUM_BIAS_EN
  assign seed        = bias;
  assign load_direct = 1'b0;
`else
  // First element bypasses the adder so a single-element job is bit-exact.
  assign seed        = FP32_ZERO;
  assign load_direct = (cnt_q == '0);
`endif

  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          cnt_d   = '0;
          acc_d   = seed;
          state_d = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          cnt_d = cnt_inc;
          acc_d = load_direct ? in_data : add_sum;
          if (cnt_inc == len_q) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= FP32_ZERO;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  assign busy      = (state_q == ACCUM) || (state_q == DONE);
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_data  = acc_q;

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// Scoreboard bench for fp_accum_ctrl; expected sums come from real-valued arithmetic
// rounded back to FP32. Define FP_ACCUM_BIAS_EN to exercise the bias build.
module tb_fp_accum_ctrl;
  import fp_pkg::*;

  localparam int MAX_LEN = 64;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  fp32_t            in_data = '0;
  logic             out_ready = 1'b0;
  logic             busy, in_ready, out_valid;
  fp32_t            out_data;
`ifdef FP_ACCUM_BIAS_EN
  fp32_t            bias = '0;
`endif

  int    checks = 0;
  int    errors = 0;
  fp32_t exp_q[$];
  fp32_t elems[$];

  always #5 clk = ~clk;

  fp_accum_ctrl #(.MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
`ifdef FP_ACCUM_BIAS_EN
    .bias      (bias),
`endif
    .busy      (busy),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference arithmetic: widen to double, add, round once back to single (RNE).
  function automatic logic [63:0] f2d(input fp32_t f);
    if (f[30:0] == 31'd0) return {f[31], 63'd0};
    return {f[31], 11'({3'b000, f[30:23]} + 11'd896), f[22:0], 29'd0};
  endfunction

  function automatic fp32_t d2f(input logic [63:0] d);
    int         fe;
    logic       up;
    logic [23:0] fr;
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    fe = int'(d[62:52]) - 896;
    up = d[28] && ((|d[27:0]) || d[29]);
    fr = {1'b0, d[51:29]} + 24'(up);
    if (fr[23]) fe++;
    if (fe >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], fe[7:0], fr[22:0]};
  endfunction

  function automatic fp32_t fadd(input fp32_t x, input fp32_t y);
    return d2f($realtobits($bitstoreal(f2d(x)) + $bitstoreal(f2d(y))));
  endfunction

  function automatic fp32_t model_sum(input fp32_t seed, input bit use_seed);
    fp32_t acc = seed;
    foreach (elems[i]) begin
      if (i == 0 && !use_seed) acc = elems[i];
      else acc = fadd(acc, elems[i]);
    end
    return acc;
  endfunction

  function automatic fp32_t expect_sum();
`ifdef FP_ACCUM_BIAS_EN
    return model_sum(bias, 1'b1);
`else
    return model_sum(FP32_ZERO, 1'b0);
`endif
  endfunction

  function automatic fp32_t rand_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
  endfunction

  // Monitor: pops the scoreboard on every result handshake, checks hold stability.
  initial begin
    fp32_t held;
    logic  held_v;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_v = 1'b0;
      end else if (out_valid) begin
        if (held_v) check("out_data_stable", out_data, held);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=%h required=none", out_data);
          end else begin
            check("result", out_data, exp_q.pop_front());
          end
          held_v = 1'b0;
        end else begin
          held   = out_data;
          held_v = 1'b1;
        end
      end
    end
  end

  // rdy_mode: 0 out_ready high, 1 random, 2 low for 5 cycles with a start pulse meanwhile
  task automatic run_job(input int n, input fp32_t expv, input int gmin, input int gmax,
                         input int rdy_mode, input bit linger);
    bit done = 1'b0;
    exp_q.push_back(expv);
    start = 1'b1;
    len   = LEN_W'(n);
    step();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("in_ready_after_start", 32'(in_ready), 32'(n != 0));
    check("out_valid_after_start", 32'(out_valid), 32'(n == 0));
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gmin, gmax)) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        step();
        check("in_ready_gap", 32'(in_ready), 32'd1);
      end
      in_valid = 1'b1;
      in_data  = elems[i];
      check("out_valid_early", 32'(out_valid), 32'd0);
      step();
    end
    in_valid = linger;
    in_data  = FP32_ONE;
    if (n > 0) begin
      check("in_ready_after_last", 32'(in_ready), 32'd0);
      check("out_valid_after_last", 32'(out_valid), 32'd1);
    end
    for (int k = 0; k < 301 && !done; k++) begin
      if (k == 300) begin
        checks++;
        errors++;
        $display("FAIL done_timeout actual=no_handshake required=handshake");
      end else begin
        case (rdy_mode)
          0: out_ready = 1'b1;
          1: out_ready = 1'($urandom_range(0, 1));
          default: begin
            out_ready = (k >= 5);
            start     = (k == 2);
            len       = LEN_W'(1);
          end
        endcase
        if (out_valid && out_ready) done = 1'b1;
        step();
      end
    end
    start     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("idle_after_handshake", 32'(busy), 32'd0);
    if (rdy_mode == 2) begin
      step();
      check("start_ignored_in_done", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int n;
    step();
    step();
    rst_n = 1'b1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", out_data, 32'h0);

    elems = '{32'h3F800000, 32'h40000000, 32'h40800000};
    run_job(3, 32'h40E00000, 0, 0, 0, 1'b0);

    elems = '{32'hC0000000, 32'h40000000};
    run_job(2, 32'h00000000, 2, 2, 0, 1'b1);

    elems.delete();
    run_job(0, 32'h00000000, 0, 0, 0, 1'b0);
    elems = '{32'h40490FDB};
    run_job(1, 32'h40490FDB, 0, 0, 0, 1'b0);

    elems = '{rand_fp(), rand_fp(), rand_fp()};
    run_job(3, expect_sum(), 0, 1, 2, 1'b1);

    // Abort a job half-way with a one-cycle reset; nothing may emerge from it.
    elems = '{32'h3F800000, 32'h40000000};
    start = 1'b1;
    len   = LEN_W'(4);
    step();
    start = 1'b0;
    foreach (elems[i]) begin
      in_valid = 1'b1;
      in_data  = elems[i];
      step();
    end
    in_data = FP32_ONE;
    rst_n   = 1'b0;
    step();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_data", out_data, 32'h0);
    repeat (3) begin
      step();
      check("abort_no_out_valid", 32'(out_valid), 32'd0);
    end
    elems = '{32'h40E00000, 32'h40C00000};
    run_job(2, 32'h41500000, 0, 0, 0, 1'b0);

`ifdef FP_ACCUM_BIAS_EN
    bias  = 32'h3F800000;
    elems = '{32'h40E00000, 32'h40C00000};
    run_job(2, 32'h41600000, 0, 0, 0, 1'b0);
    elems.delete();
    run_job(0, 32'h3F800000, 0, 0, 0, 1'b0);
`endif

    elems.delete();
    for (int i = 0; i < MAX_LEN; i++) elems.push_back(rand_fp());
    run_job(MAX_LEN, expect_sum(), 0, 0, 0, 1'b1);

    for (int j = 0; j < 25; j++) begin
`ifdef FP_ACCUM_BIAS_EN
      bias = rand_fp();
`endif
      n = (j % 5 == 0) ? 0 : int'($urandom_range(1, 20));
      elems.delete();
      for (int i = 0; i < n; i++) elems.push_back(rand_fp());
      run_job(n, expect_sum(), 0, 2, 1, 1'($urandom_range(0, 1)));
    end

    repeat (4) step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
